// File: rtl/seg7_blink_scan.sv
// Eight-digit multiplexed seven-segment driver with per-digit blink and enable,
// anti-ghost blanking and a double-buffered display image swapped at frame boundaries.
module seg7_blink_scan #(
  parameter logic [15:0] SCAN_DIV  = 16'd50000,
  parameter logic [15:0] BLANK_CYC = 16'd500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        blink_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_en,
  input  logic [7:0]  load_blink,
  input  logic [7:0]  load_dp,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  logic [15:0] scan_cnt;
  logic [2:0]  digit_idx;
  logic        pend_flag;
  logic [31:0] pend_data, act_data;
  logic [7:0]  pend_en, pend_blink, pend_dp;
  logic [7:0]  act_en, act_blink, act_dp;
  logic        slot_end, frame_end, load_fire;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'b1000000;
      4'h1: hex_decode = 7'b1111001;
      4'h2: hex_decode = 7'b0100100;
      4'h3: hex_decode = 7'b0110000;
      4'h4: hex_decode = 7'b0011001;
      4'h5: hex_decode = 7'b0010010;
      4'h6: hex_decode = 7'b0000010;
      4'h7: hex_decode = 7'b1111000;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0010000;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b0000011;
      4'hC: hex_decode = 7'b1000110;
      4'hD: hex_decode = 7'b0100001;
      4'hE: hex_decode = 7'b0000110;
      default: hex_decode = 7'b0001110;
    endcase
  endfunction

  assign slot_end   = (scan_cnt == SCAN_DIV - 16'd1);
  assign frame_end  = slot_end && (digit_idx == 3'd7);
  assign load_ready = !reset && !pend_flag;
  assign load_fire  = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= 16'd0;
      digit_idx <= 3'd0;
    end else if (slot_end) begin
      scan_cnt  <= 16'd0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      scan_cnt  <= scan_cnt + 16'd1;
    end
  end

  // A load landing on the boundary cycle sees pend_flag=0, so it is only
  // captured into pending and waits a full frame before being shown.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_flag  <= 1'b0;
      pend_data  <= 32'd0;
      pend_en    <= 8'd0;
      pend_blink <= 8'd0;
      pend_dp    <= 8'd0;
      act_data   <= 32'd0;
      act_en     <= 8'd0;
      act_blink  <= 8'd0;
      act_dp     <= 8'd0;
    end else if (frame_end && pend_flag) begin
      act_data   <= pend_data;
      act_en     <= pend_en;
      act_blink  <= pend_blink;
      act_dp     <= pend_dp;
      pend_flag  <= 1'b0;
    end else if (load_fire) begin
      pend_data  <= load_data;
      pend_en    <= load_en;
      pend_blink <= load_blink;
      pend_dp    <= load_dp;
      pend_flag  <= 1'b1;
    end
  end

  // Stage p0: digit select and lit decision from the current scan state
  logic       lit_p0;
  logic [3:0] nib_p0;
  assign nib_p0 = act_data[{digit_idx, 2'b00} +: 4];
  assign lit_p0 = act_en[digit_idx] && (scan_cnt >= BLANK_CYC)
                  && !(act_blink[digit_idx] && blink_in);

  // Stage p1: registered display drive
  logic [7:0] an_p1;
  logic [6:0] seg_p1;
  logic       dp_p1, fs_p1;
  always_ff @(posedge clk) begin
    if (reset) begin
      an_p1  <= 8'hFF;
      seg_p1 <= 7'h7F;
      dp_p1  <= 1'b1;
      fs_p1  <= 1'b0;
    end else begin
      fs_p1 <= (scan_cnt == 16'd0) && (digit_idx == 3'd0);
      if (lit_p0) begin
        an_p1  <= ~(8'd1 << digit_idx);
        seg_p1 <= hex_decode(nib_p0);
        dp_p1  <= ~act_dp[digit_idx];
      end else begin
        an_p1  <= 8'hFF;
        seg_p1 <= 7'h7F;
        dp_p1  <= 1'b1;
      end
    end
  end

  assign an          = an_p1;
  assign seg         = seg_p1;
  assign dp          = dp_p1;
  assign frame_start = fs_p1;

endmodule

// File: tb/tb_seg7_blink_scan.sv
// Scoreboard bench for seg7_blink_scan (SCAN_DIV=8, BLANK_CYC=2): expectations are
// queued against future clock ticks and a negedge monitor compares them.
module tb_seg7_blink_scan;
  localparam logic [15:0] SD = 16'd8;
  localparam logic [15:0] BC = 16'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        blink_in = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = 32'd0;
  logic [7:0]  load_en = 8'd0, load_blink = 8'd0, load_dp = 8'd0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp, frame_start;

  int tick = 0;
  int pos = 0;
  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int         tk;
    string      nm;
    logic [2:0] mask;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
    logic       rdy;
  } exp_t;
  exp_t sb[$];

  seg7_blink_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .reset(reset), .blink_in(blink_in),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_en(load_en), .load_blink(load_blink), .load_dp(load_dp),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // pos = scan position of the current state; outputs show position pos-1
  always @(posedge clk) begin
    tick <= tick + 1;
    pos  <= reset ? 0 : pos + 1;
  end

  task automatic push(input int p, input string nm, input logic [2:0] m, input logic [7:0] a,
                      input logic [6:0] s, input logic d, input logic f, input logic r);
    exp_t e;
    e.tk = tick + p - pos; e.nm = nm; e.mask = m;
    e.an = a; e.seg = s; e.dp = d; e.fs = f; e.rdy = r;
    sb.push_back(e);
  endtask

  task automatic exp_disp(input int p, input string nm, input logic [7:0] a,
                          input logic [6:0] s, input logic d);
    push(p, nm, 3'b001, a, s, d, 1'b0, 1'b0);
  endtask

  task automatic exp_fs(input int p, input string nm, input logic f);
    push(p, nm, 3'b010, 8'h00, 7'h00, 1'b0, f, 1'b0);
  endtask

  task automatic exp_rdy(input int p, input string nm, input logic r);
    push(p, nm, 3'b100, 8'h00, 7'h00, 1'b0, 1'b0, r);
  endtask

  task automatic go(input int p);
    int n = 0;
    while (pos != p && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (pos != p) begin
      errors++;
      $display("FAIL go_timeout pos=%0d required %0d", pos, p);
    end
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] e, input logic [7:0] b,
                      input logic [7:0] p);
    load_data = d; load_en = e; load_blink = b; load_dp = p; load_valid = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot tick=%0d an=%h required at most one low bit", tick, an);
      end
      if (pos == 0 || ((pos - 1) % int'(SD)) < int'(BC)) begin
        checks++;
        if (an !== 8'hFF) begin
          errors++;
          $display("FAIL blank tick=%0d pos=%0d an=%h required ff", tick, pos, an);
        end
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].tk < tick) begin
          checks++; errors++;
          $display("FAIL %s missed target tick %0d", sb[i].nm, sb[i].tk);
          sb.delete(i);
        end else if (sb[i].tk == tick) begin
          if (sb[i].mask[0]) begin
            checks++;
            if ({an, seg, dp} !== {sb[i].an, sb[i].seg, sb[i].dp}) begin
              errors++;
              $display("FAIL %s an=%h seg=%b dp=%b required an=%h seg=%b dp=%b", sb[i].nm,
                       an, seg, dp, sb[i].an, sb[i].seg, sb[i].dp);
            end
          end
          if (sb[i].mask[1]) begin
            checks++;
            if (frame_start !== sb[i].fs) begin
              errors++;
              $display("FAIL %s frame_start=%b required %b", sb[i].nm, frame_start, sb[i].fs);
            end
          end
          if (sb[i].mask[2]) begin
            checks++;
            if (load_ready !== sb[i].rdy) begin
              errors++;
              $display("FAIL %s load_ready=%b required %b", sb[i].nm, load_ready, sb[i].rdy);
            end
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    mon_on = 1'b1;
    exp_disp(pos, "rst_disp", 8'hFF, 7'h7F, 1'b1);
    exp_fs(pos, "rst_fs", 1'b0);
    exp_rdy(pos, "rst_rdy", 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rdy(pos, "rdy_first", 1'b1);
    exp_fs(pos, "fs_pre", 1'b0);

    // Image 76543210 loaded at pos 1, shown from frame 2 (positions 64..127)
    exp_fs(1, "fs0", 1'b1);
    exp_disp(1, "dark0", 8'hFF, 7'h7F, 1'b1);
    exp_fs(2, "fs0_off", 1'b0);
    exp_rdy(2, "busy1", 1'b0);
    exp_disp(20, "pre_act", 8'hFF, 7'h7F, 1'b1);
    exp_rdy(63, "busy1_end", 1'b0);
    exp_rdy(64, "rdy1_back", 1'b1);
    exp_fs(65, "fs1", 1'b1);
    exp_disp(66, "blank_d0", 8'hFF, 7'h7F, 1'b1);
    exp_disp(67, "d0_lit", 8'hFE, 7'b1000000, 1'b0);
    exp_disp(72, "d0_end", 8'hFE, 7'b1000000, 1'b0);
    exp_disp(73, "d1_blank", 8'hFF, 7'h7F, 1'b1);
    exp_disp(76, "d1_one", 8'hFD, 7'b1111001, 1'b1);
    exp_disp(84, "d2_two", 8'hFB, 7'b0100100, 1'b1);
    exp_disp(93, "d3_three", 8'hF7, 7'b0110000, 1'b1);
    exp_disp(100, "d4_four", 8'hEF, 7'b0011001, 1'b1);
    exp_disp(108, "d5_five", 8'hDF, 7'b0010010, 1'b1);
    exp_disp(117, "d6_old", 8'hBF, 7'b0000010, 1'b1);
    exp_disp(123, "d7_old", 8'h7F, 7'b1111000, 1'b1);

    // Mid-frame load FEDCBA98 at pos 100; second request at pos 110 must be dropped
    exp_rdy(100, "rdy_pre2", 1'b1);
    exp_rdy(101, "busy2", 1'b0);
    exp_rdy(111, "ign_busy", 1'b0);
    exp_rdy(127, "busy2_end", 1'b0);
    exp_rdy(128, "rdy2_back", 1'b1);
    exp_disp(131, "d0_new", 8'hFE, 7'b0000000, 1'b1);
    exp_disp(140, "d1_nine", 8'hFD, 7'b0010000, 1'b1);
    exp_disp(164, "d4_new", 8'hEF, 7'b1000110, 1'b1);
    exp_disp(172, "d5_d", 8'hDF, 7'b0100001, 1'b1);
    exp_disp(180, "d6_e", 8'hBF, 7'b0000110, 1'b1);
    exp_disp(187, "d7_new", 8'h7F, 7'b0001110, 1'b0);

    // Blink on digit 2 in frame 3; digit 3 ignores blink_in
    exp_disp(147, "blink_dark", 8'hFF, 7'h7F, 1'b1);
    exp_disp(148, "blink_dark2", 8'hFF, 7'h7F, 1'b1);
    exp_disp(150, "blink_lit", 8'hFB, 7'b0001000, 1'b1);
    exp_disp(155, "d3_unaff", 8'hF7, 7'b0000011, 1'b1);

    // Load on boundary cycle 191 with en=00: applied only at boundary 255
    exp_rdy(191, "rdy_bnd", 1'b1);
    exp_rdy(192, "busy_bnd", 1'b0);
    exp_fs(193, "fs_f4", 1'b1);
    exp_disp(195, "old_after_bnd", 8'hFE, 7'b0000000, 1'b1);
    exp_rdy(255, "busy_bnd_end", 1'b0);
    exp_rdy(256, "rdy_bnd_back", 1'b1);
    exp_fs(257, "fs_f5", 1'b1);
    exp_fs(258, "fs_f5_off", 1'b0);
    exp_disp(259, "en0_d0", 8'hFF, 7'h7F, 1'b1);
    exp_disp(300, "en0_mid", 8'hFF, 7'h7F, 1'b1);
    exp_disp(320, "en0_d7", 8'hFF, 7'h7F, 1'b1);
    exp_fs(321, "fs_f6", 1'b1);
    exp_rdy(331, "busy5", 1'b0);

    go(1);   load(32'h76543210, 8'hFF, 8'h00, 8'h01);
    go(2);   load_valid = 1'b0;
    go(100); load(32'hFEDCBA98, 8'hFF, 8'h04, 8'h80);
    go(101); load_valid = 1'b0;
    go(110); load(32'h11111111, 8'h01, 8'h00, 8'h00);
    go(111); load_valid = 1'b0;
    go(144); blink_in = 1'b1;
    go(148); blink_in = 1'b0;
    go(152); blink_in = 1'b1;
    go(158); blink_in = 1'b0;
    go(191); load(32'h55555555, 8'h00, 8'h00, 8'h00);
    go(192); load_valid = 1'b0;
    go(330); load(32'h33333333, 8'hFF, 8'h00, 8'hFF);
    go(331); load_valid = 1'b0;

    // Reset mid-frame with a pending image that must be discarded
    go(340); reset = 1'b1;
    @(posedge clk); #1;
    exp_disp(pos, "rst2_disp", 8'hFF, 7'h7F, 1'b1);
    exp_fs(pos, "rst2_fs", 1'b0);
    exp_rdy(pos, "rst2_rdy", 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rdy(pos, "rdy_after_rst", 1'b1);
    exp_fs(1, "fs_rst", 1'b1);
    exp_rdy(10, "rdy_clear", 1'b1);
    exp_disp(67, "rst_discard", 8'hFF, 7'h7F, 1'b1);
    go(70);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      load_valid = ($urandom_range(7) == 0);
      load_data  = $urandom;
      load_en    = 8'($urandom);
      load_blink = 8'($urandom);
      load_dp    = 8'($urandom);
      blink_in   = 1'($urandom_range(1));
    end
    load_valid = 1'b0;

    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", sb.size());
    end
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
